// File: rtl/cfg_port_arbiter_if.sv
// rtl/cfg_port_arbiter_if.sv - input-buffer and configuration-port signal bundle for cfg_port_arbiter
interface cfg_port_arbiter_if #(
    parameter int PORTNUM = 16,
    parameter int PW      = 4,
    parameter int CW      = 9
);
    logic [PORTNUM*CW-1:0] SpW_D_i;
    logic [PORTNUM-1:0]    empty_IBUF_i;
    logic [PORTNUM-1:0]    rd_IBUF_o;
    logic [CW-1:0]         cfg_data_o;
    logic                  cfg_valid_o;
    logic                  cfg_ready_i;
    logic                  cfg_sop_o;
    logic [PW-1:0]         cfg_port_o;
    logic                  cfg_busy_o;
    logic                  cfg_abort_o;

    modport master (
        input  SpW_D_i, empty_IBUF_i, cfg_ready_i,
        output rd_IBUF_o, cfg_data_o, cfg_valid_o, cfg_sop_o,
               cfg_port_o, cfg_busy_o, cfg_abort_o
    );

    modport slave (
        output SpW_D_i, empty_IBUF_i, cfg_ready_i,
        input  rd_IBUF_o, cfg_data_o, cfg_valid_o, cfg_sop_o,
               cfg_port_o, cfg_busy_o, cfg_abort_o
    );
endinterface

// File: rtl/cfg_port_arbiter.sv
// rtl/cfg_port_arbiter.sv - round-robin packet arbiter onto the configuration command port
// Optional mid-packet stall watchdog with EEP injection: define CFG_ARB_TIMEOUT_EN.
module cfg_port_arbiter #(
    parameter int PORTNUM = 16,
    parameter int PW      = 4,
    parameter int CW      = 9,
    parameter int TMO_W   = 10
) (
    input  logic               gclk,
    input  logic               reset,
    cfg_port_arbiter_if.master bus
);
    localparam logic [CW-1:0] EOP = CW'(9'h100);
    localparam logic [CW-1:0] EEP = CW'(9'h101);

    if (PORTNUM < 2 || PORTNUM > 16 || PW < $clog2(PORTNUM) || TMO_W < 1) begin : g_bad_param
        $error("cfg_port_arbiter: illegal parameter combination");
    end

`ifdef CFG_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT} state_t;
    localparam logic [TMO_W-1:0] WDOG_LAST = {TMO_W{1'b1}} - TMO_W'(1);
    logic [TMO_W-1:0] wdog_q, wdog_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] last_grant_q, last_grant_d;
    logic          sop_q, sop_d;

    logic          hit;
    logic [PW-1:0] hit_idx;
    logic [CW-1:0] head;
    logic          head_valid;
    logic          xfer;

    assign head       = bus.SpW_D_i[int'(grant_q)*CW +: CW];
    assign head_valid = !bus.empty_IBUF_i[grant_q];
    assign xfer       = (state_q == S_XFER) && head_valid && bus.cfg_ready_i;

    // Rotating search: the port after the last winner is looked at first, the last winner last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 1; i <= PORTNUM; i++) begin
            if (!hit && !bus.empty_IBUF_i[(int'(last_grant_q) + i) % PORTNUM]) begin
                hit     = 1'b1;
                hit_idx = PW'((int'(last_grant_q) + i) % PORTNUM);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        sop_d            = sop_q;
`ifdef CFG_ARB_TIMEOUT_EN
        wdog_d           = wdog_q;
`endif
        bus.rd_IBUF_o    = '0;
        bus.cfg_data_o   = '0;
        bus.cfg_valid_o  = 1'b0;
        bus.cfg_sop_o    = 1'b0;
        bus.cfg_abort_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    grant_d      = hit_idx;
                    last_grant_d = hit_idx;
                    sop_d        = 1'b1;
`ifdef CFG_ARB_TIMEOUT_EN
                    wdog_d       = '0;
`endif
                    state_d      = S_XFER;
                end
            end
            S_XFER: begin
                bus.cfg_valid_o = head_valid;
                bus.cfg_data_o  = head;
                bus.cfg_sop_o   = sop_q && head_valid;
                if (xfer) begin
                    bus.rd_IBUF_o[grant_q] = 1'b1;
                    sop_d = 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (head == EOP || head == EEP) begin
                        state_d = S_IDLE;
                    end
                end
`ifdef CFG_ARB_TIMEOUT_EN
                // Only a stall after the packet has started counts; waiting for the first char is not a hang.
                else if (!head_valid && !sop_q) begin
                    wdog_d = wdog_q + TMO_W'(1);
                    if (wdog_q == WDOG_LAST) begin
                        state_d = S_ABORT;
                    end
                end
`endif
            end
`ifdef CFG_ARB_TIMEOUT_EN
            S_ABORT: begin
                bus.cfg_data_o  = EEP;
                bus.cfg_valid_o = 1'b1;
                if (bus.cfg_ready_i) begin
                    bus.cfg_abort_o = 1'b1;
                    state_d         = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cfg_port_o = grant_q;
    assign bus.cfg_busy_o = (state_q != S_IDLE);

    always_ff @(posedge gclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= PW'(PORTNUM - 1);
            sop_q        <= 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sop_q        <= sop_d;
`ifdef CFG_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end
endmodule

// File: tb/tb_cfg_port_arbiter.sv
// tb/tb_cfg_port_arbiter.sv - scoreboard bench for cfg_port_arbiter
`timescale 1ns/1ps
module tb_cfg_port_arbiter;
    localparam int PORTNUM = 16;
    localparam int PW      = 4;
    localparam int CW      = 9;
    localparam int TMO_W   = 4;

    typedef struct packed {
        logic [PW-1:0] port;
        logic [CW-1:0] data;
        logic          sop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_port_arbiter_if #(.PORTNUM(PORTNUM), .PW(PW), .CW(CW)) bus();

    cfg_port_arbiter #(.PORTNUM(PORTNUM), .PW(PW), .CW(CW), .TMO_W(TMO_W)) dut (
        .gclk  (clk),
        .reset (rst),
        .bus   (bus)
    );

    exp_t        sb[$];
    logic [CW-1:0] mem [PORTNUM][64];
    int          hd [PORTNUM];
    int          tl [PORTNUM];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic drive_inputs();
        for (int p = 0; p < PORTNUM; p++) begin
            bus.empty_IBUF_i[p] = (hd[p] == tl[p]);
            bus.SpW_D_i[p*CW +: CW] = (hd[p] == tl[p]) ? '0 : mem[p][hd[p] % 64];
        end
    endtask

    task automatic fifo_put(input int p, input logic [CW-1:0] c);
        mem[p][tl[p] % 64] = c;
        tl[p]++;
        drive_inputs();
    endtask

    task automatic expect_char(input int p, input logic [CW-1:0] c, input logic sop);
        exp_t e;
        e.port = PW'(p);
        e.data = c;
        e.sop  = sop;
        sb.push_back(e);
    endtask

    // Called at the falling edge: applies this cycle's pops at the rising edge, then refreshes FIFO heads.
    task automatic advance();
        logic [PORTNUM-1:0] pv;
        pv = bus.rd_IBUF_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTNUM; p++) begin
            if (pv[p]) hd[p]++;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); advance();
        @(negedge clk); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_ready_i = 1'b1;
        @(negedge clk); advance();
        @(negedge clk);
        n_assert++; if (bus.rd_IBUF_o !== '0)   begin n_fail++; $display("FAIL reset_rd: got %h want 0", bus.rd_IBUF_o); end
        n_assert++; if (bus.cfg_data_o !== '0)  begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.cfg_data_o); end
        n_assert++; if (bus.cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.cfg_valid_o); end
        n_assert++; if (bus.cfg_sop_o !== 1'b0) begin n_fail++; $display("FAIL reset_sop: got %b want 0", bus.cfg_sop_o); end
        n_assert++; if (bus.cfg_port_o !== '0)  begin n_fail++; $display("FAIL reset_port: got %0d want 0", bus.cfg_port_o); end
        n_assert++; if (bus.cfg_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.cfg_busy_o); end
        n_assert++; if (bus.cfg_abort_o !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", bus.cfg_abort_o); end
        advance();
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        exp_t e;
        bus.cfg_ready_i = 1'b1;
        fifo_put(3, 9'h012); expect_char(3, 9'h012, 1'b1);
        fifo_put(3, 9'h034); expect_char(3, 9'h034, 1'b0);
        fifo_put(3, 9'h100); expect_char(3, 9'h100, 1'b0);
        @(negedge clk);
        n_assert++; if (bus.cfg_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid %b in request cycle, want 0", bus.cfg_valid_o); end
        advance();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (bus.cfg_valid_o !== 1'b1 || bus.cfg_data_o !== e.data || bus.cfg_sop_o !== e.sop ||
                bus.cfg_port_o !== e.port || bus.rd_IBUF_o !== (16'h1 << e.port)) begin
                n_fail++;
                $display("FAIL single_xfer%0d: got v=%b d=%h sop=%b port=%0d rd=%h, want v=1 d=%h sop=%b port=%0d",
                         k, bus.cfg_valid_o, bus.cfg_data_o, bus.cfg_sop_o, bus.cfg_port_o, bus.rd_IBUF_o, e.data, e.sop, e.port);
            end
            advance();
        end
        @(negedge clk);
        n_assert++; if (bus.cfg_busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", bus.cfg_busy_o); end
        advance();
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   refilled = 0;
        do_reset();
        bus.cfg_ready_i = 1'b1;
        fifo_put(0, 9'h0A1);  expect_char(0, 9'h0A1, 1'b1);
        fifo_put(0, 9'h100);  expect_char(0, 9'h100, 1'b0);
        fifo_put(5, 9'h0B1);  expect_char(5, 9'h0B1, 1'b1);
        fifo_put(5, 9'h100);  expect_char(5, 9'h100, 1'b0);
        fifo_put(15, 9'h0C1); expect_char(15, 9'h0C1, 1'b1);
        fifo_put(15, 9'h100); expect_char(15, 9'h100, 1'b0);
        for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop ||
                    bus.rd_IBUF_o !== (16'h1 << e.port)) begin
                    n_fail++;
                    $display("FAIL rr_xfer: got port=%0d d=%h sop=%b rd=%h, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, bus.rd_IBUF_o, e.port, e.data, e.sop);
                end
                if (!refilled && e.port == 4'd5) begin
                    refilled = 1;
                    advance();
                    fifo_put(0, 9'h0D1); expect_char(0, 9'h0D1, 1'b1);
                    fifo_put(0, 9'h100); expect_char(0, 9'h100, 1'b0);
                    continue;
                end
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL rr_drain: %0d chars still expected, want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_backpressure();
        exp_t          e;
        logic          held = 0;
        logic [CW-1:0] held_data = '0;
        fifo_put(1, 9'h011); expect_char(1, 9'h011, 1'b1);
        fifo_put(1, 9'h022); expect_char(1, 9'h022, 1'b0);
        fifo_put(1, 9'h033); expect_char(1, 9'h033, 1'b0);
        fifo_put(1, 9'h100); expect_char(1, 9'h100, 1'b0);
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            bus.cfg_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            if (bus.cfg_valid_o) begin
                n_assert++;
                if (bus.rd_IBUF_o !== (bus.cfg_ready_i ? 16'h0002 : 16'h0000)) begin
                    n_fail++;
                    $display("FAIL bp_rd: got %h with ready=%b, want %h", bus.rd_IBUF_o, bus.cfg_ready_i, bus.cfg_ready_i ? 16'h0002 : 16'h0000);
                end
                if (held) begin
                    n_assert++;
                    if (bus.cfg_data_o !== held_data) begin
                        n_fail++;
                        $display("FAIL bp_hold: got %h want %h", bus.cfg_data_o, held_data);
                    end
                end
                if (bus.cfg_ready_i) begin
                    e = sb.pop_front();
                    n_assert++;
                    if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                        n_fail++;
                        $display("FAIL bp_xfer: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                                 bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                    end
                end
                held      = !bus.cfg_ready_i;
                held_data = bus.cfg_data_o;
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL bp_drain: %0d chars still expected, want 0", sb.size()); sb.delete(); end
        bus.cfg_ready_i = 1'b1;
        @(negedge clk); advance();
    endtask

    task automatic test_eep();
        exp_t e;
        bit   gap_due = 0;
        bus.cfg_ready_i = 1'b1;
        fifo_put(4, 9'h1FF); expect_char(4, 9'h1FF, 1'b1);
        fifo_put(4, 9'h101); expect_char(4, 9'h101, 1'b0);
        fifo_put(6, 9'h061); expect_char(6, 9'h061, 1'b1);
        fifo_put(6, 9'h100); expect_char(6, 9'h100, 1'b0);
        for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (gap_due) begin
                gap_due = 0;
                n_assert++;
                if (bus.cfg_busy_o !== 1'b0 || bus.cfg_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL eep_gap: got busy=%b valid=%b, want 0 0", bus.cfg_busy_o, bus.cfg_valid_o);
                end
            end
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                    n_fail++;
                    $display("FAIL eep_xfer: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                end
                if (e.data == 9'h101) gap_due = 1;
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL eep_drain: %0d chars still expected, want 0", sb.size()); sb.delete(); end
        @(negedge clk); advance();
    endtask

    task automatic test_watchdog();
        exp_t e;
        bus.cfg_ready_i = 1'b1;
        fifo_put(2, 9'h055); expect_char(2, 9'h055, 1'b1);
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                    n_fail++;
                    $display("FAIL wd_first: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                end
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL wd_start: first char not transferred"); sb.delete(); end
        fifo_put(7, 9'h071);
        fifo_put(7, 9'h100);
`ifdef CFG_ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_assert++;
            if (bus.cfg_valid_o !== 1'b0 || bus.cfg_busy_o !== 1'b1 || bus.cfg_abort_o !== 1'b0 || bus.cfg_port_o !== 4'd2) begin
                n_fail++;
                $display("FAIL wd_wait%0d: got v=%b busy=%b abort=%b port=%0d, want 0 1 0 2",
                         k, bus.cfg_valid_o, bus.cfg_busy_o, bus.cfg_abort_o, bus.cfg_port_o);
            end
            advance();
        end
        @(negedge clk);
        n_assert++;
        if (bus.cfg_valid_o !== 1'b1 || bus.cfg_data_o !== 9'h101 || bus.cfg_abort_o !== 1'b1 || bus.rd_IBUF_o !== '0) begin
            n_fail++;
            $display("FAIL wd_abort: got v=%b d=%h abort=%b rd=%h, want 1 101 1 0",
                     bus.cfg_valid_o, bus.cfg_data_o, bus.cfg_abort_o, bus.rd_IBUF_o);
        end
        advance();
        @(negedge clk);
        n_assert++;
        if (bus.cfg_busy_o !== 1'b0 || bus.cfg_abort_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_release: got busy=%b abort=%b, want 0 0", bus.cfg_busy_o, bus.cfg_abort_o);
        end
        advance();
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_assert++;
            if (bus.cfg_valid_o !== 1'b0 || bus.cfg_busy_o !== 1'b1 || bus.cfg_port_o !== 4'd2 || bus.cfg_abort_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_hold%0d: got v=%b busy=%b port=%0d abort=%b, want 0 1 2 0",
                         k, bus.cfg_valid_o, bus.cfg_busy_o, bus.cfg_port_o, bus.cfg_abort_o);
            end
            advance();
        end
        fifo_put(2, 9'h100); expect_char(2, 9'h100, 1'b0);
`endif
        expect_char(7, 9'h071, 1'b1);
        expect_char(7, 9'h100, 1'b0);
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                    n_fail++;
                    $display("FAIL wd_next: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                end
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL wd_drain: %0d chars still expected, want 0", sb.size()); sb.delete(); end
        @(negedge clk); advance();
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        bus.cfg_ready_i = 1'b1;
        fifo_put(0, 9'h0E1); expect_char(0, 9'h0E1, 1'b1);
        fifo_put(0, 9'h0E2); expect_char(0, 9'h0E2, 1'b0);
        fifo_put(0, 9'h0E3);
        fifo_put(0, 9'h100);
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                    n_fail++;
                    $display("FAIL rst_pre: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                end
            end
            advance();
        end
        bus.cfg_ready_i = 1'b0;
        rst = 1'b1;
        fifo_put(5, 9'h051);
        fifo_put(5, 9'h100);
        @(negedge clk); advance();
        @(negedge clk);
        n_assert++;
        if (bus.cfg_valid_o !== 1'b0 || bus.cfg_busy_o !== 1'b0 || bus.rd_IBUF_o !== '0 ||
            bus.cfg_data_o !== '0 || bus.cfg_port_o !== '0 || bus.cfg_sop_o !== 1'b0 || bus.cfg_abort_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b busy=%b rd=%h d=%h port=%0d sop=%b abort=%b, want all 0",
                     bus.cfg_valid_o, bus.cfg_busy_o, bus.rd_IBUF_o, bus.cfg_data_o, bus.cfg_port_o, bus.cfg_sop_o, bus.cfg_abort_o);
        end
        advance();
        rst = 1'b0;
        bus.cfg_ready_i = 1'b1;
        expect_char(0, 9'h0E3, 1'b1);
        expect_char(0, 9'h100, 1'b0);
        expect_char(5, 9'h051, 1'b1);
        expect_char(5, 9'h100, 1'b0);
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.cfg_valid_o && bus.cfg_ready_i) begin
                e = sb.pop_front();
                n_assert++;
                if (bus.cfg_data_o !== e.data || bus.cfg_port_o !== e.port || bus.cfg_sop_o !== e.sop) begin
                    n_fail++;
                    $display("FAIL rst_post: got port=%0d d=%h sop=%b, want port=%0d d=%h sop=%b",
                             bus.cfg_port_o, bus.cfg_data_o, bus.cfg_sop_o, e.port, e.data, e.sop);
                end
            end
            advance();
        end
        n_assert++; if (sb.size() !== 0) begin n_fail++; $display("FAIL rst_drain: %0d chars still expected, want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        rst = 1'b1;
        bus.cfg_ready_i = 1'b0;
        for (int p = 0; p < PORTNUM; p++) begin
            hd[p] = 0;
            tl[p] = 0;
        end
        drive_inputs();
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_eep();
        test_watchdog();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
